// File: rtl/switch_allocator.sv
// Per-output round-robin switch allocator holding wormhole reservations until the tail handshake.
// Optional per-output grant counters are built when SA_GRANT_COUNT_EN is defined.

module switch_allocator_out #(
    parameter int INPUTS        = 4,
    parameter int REQUEST_WIDTH = 32,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [INPUTS-1:0]        cand,
    input  logic [INPUTS-1:0]        rel_hs,
    output logic                     busy,
    output logic [REQUEST_WIDTH-1:0] sel,
    output logic [INPUTS-1:0]        grant_mask,
    output logic [INPUTS-1:0]        rel_mask
`ifdef SA_GRANT_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0]     cnt
`endif
);
    localparam int IW = (INPUTS > 1) ? $clog2(INPUTS) : 1;
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [0:0]    state;
    logic [IW-1:0] rr_ptr, owner, win_idx;
    logic          win_found, grant, release_now;

    // Search begins one past the last winner and wraps around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= INPUTS; k++) begin
            if (!win_found && cand[(int'(rr_ptr) + k) % INPUTS]) begin
                win_found = 1'b1;
                win_idx   = IW'((int'(rr_ptr) + k) % INPUTS);
            end
        end
    end

    assign grant       = (state == IDLE) && win_found;
    assign release_now = (state == ACTIVE) && rel_hs[owner];

    always_comb begin
        grant_mask = '0;
        rel_mask   = '0;
        for (int i = 0; i < INPUTS; i++) begin
            grant_mask[i] = grant && (win_idx == IW'(i));
            rel_mask[i]   = release_now && (owner == IW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= IW'(INPUTS - 1);
            owner  <= '0;
        end else if (grant) begin
            state  <= ACTIVE;
            rr_ptr <= win_idx;
            owner  <= win_idx;
        end else if (release_now) begin
            state  <= IDLE;
        end
    end

`ifdef SA_GRANT_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     cnt <= '0;
        else if (grant) cnt <= cnt + 1'b1;
    end
`endif

    assign busy = (state == ACTIVE);
    // owner only changes on a grant, so routeSelect keeps its value after release.
    assign sel  = REQUEST_WIDTH'(owner);
endmodule

module switch_allocator #(
    parameter int INPUTS        = 4,
    parameter int OUTPUTS       = 4,
    parameter int REQUEST_WIDTH = 32,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [INPUTS-1:0]                      req_valid,
    input  logic [INPUTS-1:0][REQUEST_WIDTH-1:0]   req_port,
    input  logic [INPUTS-1:0]                      tail_in,
    input  logic [INPUTS-1:0]                      valid_in,
    input  logic [INPUTS-1:0]                      ready_in,
    output logic [OUTPUTS-1:0][REQUEST_WIDTH-1:0]  routeSelect,
    output logic [OUTPUTS-1:0]                     outputBusy,
    output logic [INPUTS-1:0]                      PortReserved,
    output logic                                   err_bad_port
`ifdef SA_GRANT_COUNT_EN
    ,
    output logic [OUTPUTS-1:0][CNT_WIDTH-1:0]      grant_count
`endif
);
    logic [OUTPUTS-1:0][INPUTS-1:0] cand, gmask, rmask;
    logic [INPUTS-1:0]              set_res, clr_res, rel_hs;
    logic                           bad_req;

    assign rel_hs = valid_in & ready_in & tail_in;

    // A reserved input ignores req_valid/req_port until its packet releases.
    always_comb begin
        bad_req = 1'b0;
        for (int o = 0; o < OUTPUTS; o++) begin
            for (int i = 0; i < INPUTS; i++) begin
                cand[o][i] = req_valid[i] && !PortReserved[i] &&
                             (req_port[i] == REQUEST_WIDTH'(o));
            end
        end
        for (int i = 0; i < INPUTS; i++) begin
            if (req_valid[i] && !PortReserved[i] &&
                (req_port[i] >= REQUEST_WIDTH'(OUTPUTS)))
                bad_req = 1'b1;
        end
    end

    always_comb begin
        set_res = '0;
        clr_res = '0;
        for (int o = 0; o < OUTPUTS; o++) begin
            set_res = set_res | gmask[o];
            clr_res = clr_res | rmask[o];
        end
    end

    for (genvar o = 0; o < OUTPUTS; o++) begin : g_out
        switch_allocator_out #(
            .INPUTS        (INPUTS),
            .REQUEST_WIDTH (REQUEST_WIDTH),
            .CNT_WIDTH     (CNT_WIDTH)
        ) u_out (
            .clk        (clk),
            .rst_n      (rst_n),
            .cand       (cand[o]),
            .rel_hs     (rel_hs),
            .busy       (outputBusy[o]),
            .sel        (routeSelect[o]),
            .grant_mask (gmask[o]),
            .rel_mask   (rmask[o])
`ifdef SA_GRANT_COUNT_EN
            ,
            .cnt        (grant_count[o])
`endif
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PortReserved <= '0;
            err_bad_port <= 1'b0;
        end else begin
            PortReserved <= (PortReserved & ~clr_res) | set_res;
            if (bad_req) err_bad_port <= 1'b1;
        end
    end
endmodule

// File: tb/tb_switch_allocator.sv
// Directed table-driven bench for switch_allocator, plus async-reset and grant-counter sequences.

module tb_switch_allocator;
    localparam int NI = 4;
    localparam int NO = 4;
    localparam int RW = 32;
    localparam int CW = 2;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NI-1:0]          req_valid, tail_in, valid_in, ready_in;
    logic [NI-1:0][RW-1:0]  req_port;
    logic [NO-1:0][RW-1:0]  routeSelect;
    logic [NO-1:0]          outputBusy;
    logic [NI-1:0]          PortReserved;
    logic                   err_bad_port;
`ifdef SA_GRANT_COUNT_EN
    logic [NO-1:0][CW-1:0]  grant_count;
`endif

    int n_vec = 0;
    int n_bad = 0;

    switch_allocator #(
        .INPUTS(NI), .OUTPUTS(NO), .REQUEST_WIDTH(RW), .CNT_WIDTH(CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_port     (req_port),
        .tail_in      (tail_in),
        .valid_in     (valid_in),
        .ready_in     (ready_in),
        .routeSelect  (routeSelect),
        .outputBusy   (outputBusy),
        .PortReserved (PortReserved),
        .err_bad_port (err_bad_port)
`ifdef SA_GRANT_COUNT_EN
        ,
        .grant_count  (grant_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NI-1:0]          rv;
        logic [NI-1:0][RW-1:0]  rp;
        logic [NI-1:0]          tl, vl, rd;
        logic [NO-1:0]          busy;
        logic [NI-1:0]          resv;
        logic                   err;
        logic [NO-1:0][1:0]     sel;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [NI-1:0][RW-1:0] P(logic [RW-1:0] a0, a1, a2, a3);
        logic [NI-1:0][RW-1:0] r;
        r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
        return r;
    endfunction

    function automatic logic [NO-1:0][1:0] S(logic [1:0] s0, s1, s2, s3);
        logic [NO-1:0][1:0] r;
        r[0] = s0; r[1] = s1; r[2] = s2; r[3] = s3;
        return r;
    endfunction

    function automatic vec_t mk(logic [3:0] rv, logic [NI-1:0][RW-1:0] rp,
                                logic [3:0] tl, vl, rd, busy, resv,
                                logic err, logic [NO-1:0][1:0] sel);
        vec_t v;
        v.rv = rv; v.rp = rp; v.tl = tl; v.vl = vl; v.rd = rd;
        v.busy = busy; v.resv = resv; v.err = err; v.sel = sel;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] rv, input logic [NI-1:0][RW-1:0] rp,
                         input logic [3:0] tl, vl, rd);
        req_valid = rv; req_port = rp; tail_in = tl; valid_in = vl; ready_in = rd;
    endtask

    logic [NI-1:0][RW-1:0] Z;

    initial begin
        Z = P(0, 0, 0, 0);
        drive(4'b0, Z, 4'b0, 4'b0, 4'b0);

        // Four idle cycles, then input 2 requests output 1 in cycle 5.
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(4'b0, Z, 4'b0, 4'b0, 4'b0, 4'b0000, 4'b0000, 1'b0, S(0,0,0,0)));
        tbl.push_back(mk(4'b0100, P(0,0,1,0), 4'b0, 4'b0, 4'b0, 4'b0010, 4'b0100, 1'b0, S(0,2,0,0)));
        tbl.push_back(mk(4'b0, Z, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b0, S(0,0,0,0)));
        // Inputs 0,1,3 contend for output 3 with 2-flit packets: order 0,1,3,0.
        tbl.push_back(mk(4'b1011, P(3,3,0,3), 4'b0000, 4'b1111, 4'b1111, 4'b1000, 4'b0001, 1'b0, S(0,0,0,0)));
        tbl.push_back(mk(4'b1011, P(3,3,0,3), 4'b0000, 4'b1111, 4'b1111, 4'b1000, 4'b0001, 1'b0, S(0,0,0,0)));
        tbl.push_back(mk(4'b1011, P(3,3,0,3), 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0, S(0,0,0,0)));
        tbl.push_back(mk(4'b1011, P(3,3,0,3), 4'b0000, 4'b1111, 4'b1111, 4'b1000, 4'b0010, 1'b0, S(0,0,0,1)));
        tbl.push_back(mk(4'b1011, P(3,3,0,3), 4'b0000, 4'b1111, 4'b1111, 4'b1000, 4'b0010, 1'b0, S(0,0,0,1)));
        tbl.push_back(mk(4'b1011, P(3,3,0,3), 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0, S(0,0,0,0)));
        tbl.push_back(mk(4'b1011, P(3,3,0,3), 4'b0000, 4'b1111, 4'b1111, 4'b1000, 4'b1000, 1'b0, S(0,0,0,3)));
        tbl.push_back(mk(4'b1011, P(3,3,0,3), 4'b0000, 4'b1111, 4'b1111, 4'b1000, 4'b1000, 1'b0, S(0,0,0,3)));
        tbl.push_back(mk(4'b1011, P(3,3,0,3), 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0, S(0,0,0,0)));
        tbl.push_back(mk(4'b1011, P(3,3,0,3), 4'b0000, 4'b1111, 4'b1111, 4'b1000, 4'b0001, 1'b0, S(0,0,0,0)));
        tbl.push_back(mk(4'b1011, P(3,3,0,3), 4'b0000, 4'b1111, 4'b1111, 4'b1000, 4'b0001, 1'b0, S(0,0,0,0)));
        tbl.push_back(mk(4'b0000, Z,          4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0, S(0,0,0,0)));
        // Input 1 holds output 0 through four stalled tail cycles.
        tbl.push_back(mk(4'b0010, Z, 4'b0010, 4'b0010, 4'b0000, 4'b0001, 4'b0010, 1'b0, S(1,0,0,0)));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(4'b0010, Z, 4'b0010, 4'b0010, 4'b0000, 4'b0001, 4'b0010, 1'b0, S(1,0,0,0)));
        tbl.push_back(mk(4'b0000, Z, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 1'b0, S(0,0,0,0)));
        // Out-of-range ports, including one that aliases output 2 in its low bits.
        tbl.push_back(mk(4'b0001, P(7,0,0,0), 4'b0, 4'b0, 4'b0, 4'b0000, 4'b0000, 1'b1, S(0,0,0,0)));
        tbl.push_back(mk(4'b1000, P(0,0,0,32'h0001_0002), 4'b0, 4'b0, 4'b0, 4'b0000, 4'b0000, 1'b1, S(0,0,0,0)));
        tbl.push_back(mk(4'b0000, Z, 4'b0, 4'b0, 4'b0, 4'b0000, 4'b0000, 1'b1, S(0,0,0,0)));
        tbl.push_back(mk(4'b0001, P(2,0,0,0), 4'b0, 4'b0, 4'b0, 4'b0100, 4'b0001, 1'b1, S(0,0,0,0)));
        tbl.push_back(mk(4'b0000, Z, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1, S(0,0,0,0)));

        #2;
        chk("reset busy", 64'(outputBusy), 64'd0);
        chk("reset resv", 64'(PortReserved), 64'd0);
        chk("reset err", 64'(err_bad_port), 64'd0);
        chk("reset sel", 64'(routeSelect[3]), 64'd0);
        #10 rst_n = 1'b1;

        foreach (tbl[r]) begin
            drive(tbl[r].rv, tbl[r].rp, tbl[r].tl, tbl[r].vl, tbl[r].rd);
            step();
            chk($sformatf("row%0d busy", r), 64'(outputBusy), 64'(tbl[r].busy));
            chk($sformatf("row%0d resv", r), 64'(PortReserved), 64'(tbl[r].resv));
            chk($sformatf("row%0d err", r), 64'(err_bad_port), 64'(tbl[r].err));
            for (int o = 0; o < NO; o++)
                if (tbl[r].busy[o])
                    chk($sformatf("row%0d sel%0d", r, o), 64'(routeSelect[o]), 64'(tbl[r].sel[o]));
        end

        // Two outputs active, then asynchronous reset between clock edges.
        drive(4'b0110, P(0,0,1,0), 4'b0, 4'b0, 4'b0);
        step();
        chk("pre-rst busy", 64'(outputBusy), 64'b0011);
        chk("pre-rst resv", 64'(PortReserved), 64'b0110);
        drive(4'b0, Z, 4'b0, 4'b0, 4'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async busy", 64'(outputBusy), 64'd0);
        chk("async resv", 64'(PortReserved), 64'd0);
        chk("async err", 64'(err_bad_port), 64'd0);
        chk("async sel", 64'({routeSelect[1], routeSelect[0]}), 64'd0);
        #2 rst_n = 1'b1;
        drive(4'b0101, Z, 4'b0, 4'b0, 4'b0);
        step();
        chk("post-rst sel0", 64'(routeSelect[0]), 64'd0);
        chk("post-rst resv", 64'(PortReserved), 64'b0001);
        drive(4'b0100, Z, 4'b0001, 4'b0001, 4'b0001);
        step();
        chk("post-rst release", 64'(outputBusy), 64'd0);
        step();
        chk("post-rst next sel0", 64'(routeSelect[0]), 64'd2);
        chk("post-rst next resv", 64'(PortReserved), 64'b0100);

`ifdef SA_GRANT_COUNT_EN
        drive(4'b0, Z, 4'b0, 4'b0, 4'b0);
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        // Single-flit packets from input 0: grant and release alternate each cycle.
        drive(4'b0001, P(2,0,0,0), 4'b0001, 4'b0001, 4'b0001);
        for (int k = 0; k < 9; k++) begin
            step();
            chk($sformatf("sf%0d busy2", k), 64'(outputBusy[2]), 64'((k % 2) == 0));
        end
        drive(4'b0, Z, 4'b0001, 4'b0001, 4'b0001);
        step();
        chk("cnt2 wrap", 64'(grant_count[2]), 64'd1);
        chk("cnt0", 64'(grant_count[0]), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Sequential control logic that drives the mux-based crossbar's select/reservation inputs: `routeSelect`, `outputBusy`, `PortReserved`.
- Takes per-input output-port requests from route computation and arbitrates round-robin per output.
- Holds each reservation for a whole wormhole packet and releases it on the tail-flit handshake.
- Sits between the per-input buffers/route computation and the crossbar inside each router.

Parameters:
- INPUTS, 4, number of crossbar input ports.
- OUTPUTS, 4, number of crossbar output ports.
- REQUEST_WIDTH, 32, width of each `req_port` and `routeSelect` entry.
- CNT_WIDTH, 16, width of each grant counter (optional feature only).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  [INPUTS]  input i has a head flit requesting an output.
- req_port  input  [INPUTS][REQUEST_WIDTH]  requested output index for input i.
- tail_in  input  [INPUTS]  current flit at input i is a packet tail.
- valid_in  input  [INPUTS]  flit valid at input i (same signal the crossbar sees).
- ready_in  input  [INPUTS]  ready returned to input i by the crossbar.
- routeSelect  output  [OUTPUTS][REQUEST_WIDTH]  input index feeding output o.
- outputBusy  output  [OUTPUTS]  output o is allocated.
- PortReserved  output  [INPUTS]  input i holds an output.
- err_bad_port  output  1  sticky: a request with `req_port >= OUTPUTS` was seen.
- grant_count  output  [OUTPUTS][CNT_WIDTH]  grants per output (optional feature only).

Behaviour:
- Reset (async, `rst_n`=0): all outputs are 0.
  - `routeSelect`=0, `outputBusy`=0, `PortReserved`=0, `err_bad_port`=0.
  - Round-robin pointers `rr_ptr[o]`=INPUTS-1, so input 0 has first priority.
  - All FSMs go to IDLE.
- Reset mid-packet: reservations drop immediately and asynchronously; there is no packet recovery.
- All outputs are registered. Nothing combinational flows from input to output.
- Each output o has its own FSM with two states, IDLE and ACTIVE.
- IDLE, candidate set: inputs i with `req_valid[i]` & `req_port[i]==o` & `!PortReserved[i]`.
- IDLE, arbitration: search starts at `(rr_ptr[o]+1) mod INPUTS` and wraps; the first candidate wins.
- IDLE, on a win by input i, registered for the next cycle:
  - `outputBusy[o]`=1
  - `routeSelect[o]`=i, zero-extended to REQUEST_WIDTH
  - `PortReserved[i]`=1
  - `rr_ptr[o]`=i
  - state becomes ACTIVE
- IDLE with no candidates: state and pointer are unchanged.
- ACTIVE, with i=`routeSelect[o]`: release when `valid_in[i]` & `ready_in[i]` & `tail_in[i]` in the same cycle.
  - Next cycle: `outputBusy[o]`=0, `PortReserved[i]`=0, state IDLE.
  - `routeSelect[o]` holds its last value.
- ACTIVE, all other cycles: hold. Body flits and stalled handshakes do not change state.
- Grant latency: a request in cycle N gives a grant visible in cycle N+1 at the earliest.
- Release to next grant: at least one bubble cycle. There is no re-grant in the release cycle.
- Single-flit packet (head is tail): grant in N+1; release follows the first completed handshake.
- Conflict-free by construction:
  - Each input names one output, so at most one output can grant a given input per cycle.
  - A reserved input is never a candidate.
- Width rules:
  - `req_port` is compared at full REQUEST_WIDTH.
  - Any `req_valid` with `req_port >= OUTPUTS` is never granted and sets `err_bad_port` until reset.
- Deasserting `req_valid` before a grant withdraws the request; no state is retained.
- Once a grant is made, `req_valid` and `req_port` are ignored for that input until release.

Optional Feature:
- Macro: SA_GRANT_COUNT_EN.
- Defined:
  - `grant_count[o]` increments by 1 on every IDLE->ACTIVE transition of output o.
  - Wraps modulo 2^CNT_WIDTH.
  - Resets to 0.
- Undefined:
  - The `grant_count` port and its counters are absent.
  - All other behaviour is identical.

Test Plan:
1. Reset, then input 2 requests `req_port`=1 in cycle 5 → cycle 6: `outputBusy`=4'b0010, `routeSelect[1]`=2, `PortReserved`=4'b0100.
2. Inputs 0, 1, 3 all request output 3 continuously, each sending a 2-flit packet → grant order 0, 1, 3, 0; exactly one idle cycle between each release and the next grant.
3. Input 1 holds output 0 while `ready_in[1]`=0 and `tail_in[1]`=1 for 4 cycles, then `ready_in[1]`=1 → reservation held through all stall cycles, released in the cycle after the handshake.
4. Input 0 requests `req_port`=7 (OUTPUTS=4) → no grant, `err_bad_port`=1 next cycle and it stays 1; a later valid request still gets a grant.
5. Assert `rst_n`=0 asynchronously mid-packet with 2 outputs ACTIVE → all outputs 0 immediately, no clock edge needed; after release, input 0 wins first.
6. With SA_GRANT_COUNT_EN defined and CNT_WIDTH=2, run 5 single-flit grants on output 2 → `grant_count[2]`=1 (wrapped).
